// File: rtl/vector_pkg.sv
// Shared definitions for the vector load/store pipes (ldp, stp).
package vector_pkg;

    localparam int VEC_VLEN_MAX = 64;
    localparam int VEC_REG_W    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } ldp_state_t;

endpackage

// File: rtl/ldp_addr_gen.sv
// Strided address accumulator for ldp: holds the current element address,
// counts issued elements and flags the last one.
module ldp_addr_gen
    import vector_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int VL_W   = $clog2(VEC_VLEN_MAX) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic [VL_W-1:0]   vl,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [VL_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        // NOTE: each _d starts from its held value so no branch can leave it unassigned and infer a latch.
        addr_d   = addr_q;
        stride_d = stride_q;
        cnt_d    = cnt_q;
        if (load) begin
            addr_d   = base;
            stride_d = stride;
            cnt_d    = '0;
        end else if (advance) begin
            addr_d = addr_q + stride_q;
            cnt_d  = cnt_q + VL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking updates so every flop samples pre-edge values regardless of block order.
        if (reset) begin
            addr_q   <= '0;
            stride_q <= '0;
            cnt_q    <= '0;
        end else begin
            addr_q   <= addr_d;
            stride_q <= stride_d;
            cnt_q    <= cnt_d;
        end
    end

    assign addr = addr_q;
    assign last = (cnt_q == vl - VL_W'(1));

endmodule

// File: rtl/ldp.sv
// Vector load pipe: issues one strided read per element, writes the in-order
// responses into the vector register file and pulses done on the last one.
module ldp
    import vector_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int VLEN_MAX = VEC_VLEN_MAX,
    parameter int REG_W    = VEC_REG_W,
    parameter int MAX_OUT  = 4,
    localparam int VL_W    = $clog2(VLEN_MAX) + 1,
    localparam int IDX_W   = $clog2(VLEN_MAX),
    localparam int OUT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_stride,
    input  logic [VL_W-1:0]   cmd_vl,
    input  logic [REG_W-1:0]  cmd_vd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              vrf_we,
    output logic [REG_W-1:0]  vrf_vd,
    output logic [IDX_W-1:0]  vrf_idx,
    output logic [DATA_W-1:0] vrf_data,
    output logic              done,
    output logic              busy,
    output logic              proto_err
);

    localparam logic [OUT_W-1:0] OUT_LIMIT = OUT_W'(MAX_OUT);

    ldp_state_t        state_q, state_d;
    logic [VL_W-1:0]   vl_q, vl_d;
    logic [REG_W-1:0]  vd_q, vd_d;
    logic [VL_W-1:0]   rsp_cnt_q, rsp_cnt_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              vrf_we_q, vrf_we_d;
    logic [REG_W-1:0]  vrf_vd_q, vrf_vd_d;
    logic [IDX_W-1:0]  vrf_idx_q, vrf_idx_d;
    logic [DATA_W-1:0] vrf_data_q, vrf_data_d;
    logic              done_q, done_d;
    logic              proto_err_q, proto_err_d;

    logic load;
    logic req_hs;
    logic rsp_ok;
    logic last;

    assign cmd_ready     = (state_q == IDLE);
    assign mem_req_valid = (state_q == ISSUE) && (out_q < OUT_LIMIT);
    assign req_hs        = mem_req_valid && mem_req_ready;
    // A response with nothing outstanding is a protocol error and is dropped.
    assign rsp_ok        = mem_rsp_valid && (out_q != '0);
    assign load          = cmd_ready && cmd_valid && (cmd_vl != '0);

    ldp_addr_gen #(
        .ADDR_W (ADDR_W),
        .VL_W   (VL_W)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .base    (cmd_base),
        .stride  (cmd_stride),
        .vl      (vl_q),
        .advance (req_hs),
        .addr    (mem_req_addr),
        .last    (last)
    );

    always_comb begin
        state_d     = state_q;
        vl_d        = vl_q;
        vd_d        = vd_q;
        rsp_cnt_d   = rsp_cnt_q;
        out_d       = out_q;
        vrf_we_d    = 1'b0;
        vrf_vd_d    = vrf_vd_q;
        vrf_idx_d   = vrf_idx_q;
        vrf_data_d  = vrf_data_q;
        done_d      = 1'b0;
        proto_err_d = proto_err_q | (mem_rsp_valid & ~rsp_ok);

        if (rsp_ok) begin
            vrf_we_d   = 1'b1;
            vrf_vd_d   = vd_q;
            vrf_idx_d  = rsp_cnt_q[IDX_W-1:0];
            vrf_data_d = mem_rsp_data;
            rsp_cnt_d  = rsp_cnt_q + VL_W'(1);
            done_d     = (rsp_cnt_q + VL_W'(1)) == vl_q;
        end

        if (req_hs && !rsp_ok) begin
            out_d = out_q + OUT_W'(1);
        end else if (!req_hs && rsp_ok) begin
            out_d = out_q - OUT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_vl == '0) begin
                        done_d = 1'b1;
                    end else begin
                        vl_d      = cmd_vl;
                        vd_d      = cmd_vd;
                        rsp_cnt_d = '0;
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (req_hs && last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (rsp_cnt_q == vl_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            vl_q        <= '0;
            vd_q        <= '0;
            rsp_cnt_q   <= '0;
            out_q       <= '0;
            vrf_we_q    <= 1'b0;
            vrf_vd_q    <= '0;
            vrf_idx_q   <= '0;
            vrf_data_q  <= '0;
            done_q      <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            vl_q        <= vl_d;
            vd_q        <= vd_d;
            rsp_cnt_q   <= rsp_cnt_d;
            out_q       <= out_d;
            vrf_we_q    <= vrf_we_d;
            vrf_vd_q    <= vrf_vd_d;
            vrf_idx_q   <= vrf_idx_d;
            vrf_data_q  <= vrf_data_d;
            done_q      <= done_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign vrf_we    = vrf_we_q;
    assign vrf_vd    = vrf_vd_q;
    assign vrf_idx   = vrf_idx_q;
    assign vrf_data  = vrf_data_q;
    assign done      = done_q;
    assign proto_err = proto_err_q;
    assign busy      = (state_q != IDLE) || vrf_we_q;

endmodule

// File: tb/tb_ldp.sv
// Self-checking bench for ldp: in-order memory model with configurable latency
// and random ready stalls; expected requests and VRF writes are compared in order.
module tb_ldp;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 64;
    localparam int VLEN_MAX = 64;
    localparam int REG_W    = 5;
    localparam int MAX_OUT  = 4;
    localparam int VL_W     = 7;
    localparam int IDX_W    = 6;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic [ADDR_W-1:0] cmd_stride = '0;
    logic [VL_W-1:0]   cmd_vl = '0;
    logic [REG_W-1:0]  cmd_vd = '0;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b1;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [DATA_W-1:0] mem_rsp_data;
    logic              vrf_we;
    logic [REG_W-1:0]  vrf_vd;
    logic [IDX_W-1:0]  vrf_idx;
    logic [DATA_W-1:0] vrf_data;
    logic              done;
    logic              busy;
    logic              proto_err;

    logic              mdl_rsp_valid = 1'b0;
    logic [DATA_W-1:0] mdl_rsp_data = '0;
    logic              spur_valid = 1'b0;
    logic [DATA_W-1:0] spur_data = '0;

    assign mem_rsp_valid = mdl_rsp_valid | spur_valid;
    assign mem_rsp_data  = spur_valid ? spur_data : mdl_rsp_data;

    ldp #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .VLEN_MAX (VLEN_MAX),
        .REG_W    (REG_W),
        .MAX_OUT  (MAX_OUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base      (cmd_base),
        .cmd_stride    (cmd_stride),
        .cmd_vl        (cmd_vl),
        .cmd_vd        (cmd_vd),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .vrf_we        (vrf_we),
        .vrf_vd        (vrf_vd),
        .vrf_idx       (vrf_idx),
        .vrf_data      (vrf_data),
        .done          (done),
        .busy          (busy),
        .proto_err     (proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } pend_t;

    typedef struct {
        logic [IDX_W-1:0]  idx;
        logic [REG_W-1:0]  vd;
        logic [DATA_W-1:0] data;
        logic              done;
        int                cyc;
    } vrf_rec_t;

    pend_t             pend_q[$];
    logic [ADDR_W-1:0] obs_req_addr[$];
    int                obs_req_cyc[$];
    vrf_rec_t          obs_vrf[$];
    int                rsp_cyc_q[$];

    int mem_lat = 2;
    bit stall_en = 1'b0;
    int hs_tot = 0;
    int rsp_tot = 0;
    int max_live = 0;
    int full_viol = 0;
    int stall_viol = 0;
    int stall_cnt = 0;
    bit prev_stall = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;

    int n_checks = 0;
    int n_errors = 0;
    int last_r0 = 0;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {~a, a ^ 32'h5A5A_0000};
    endfunction

    // Memory model and monitor: observe at negedge, drive just after posedge.
    always begin
        int cur;
        vrf_rec_t r;
        pend_t p;
        @(negedge clk);
        if (reset) begin
            hs_tot     = 0;
            rsp_tot    = 0;
            prev_stall = 1'b0;
        end else begin
            cur = hs_tot - rsp_tot;
            if (cur > max_live) max_live = cur;
            if (cur >= MAX_OUT && mem_req_valid) full_viol++;
            if (prev_stall && (!mem_req_valid || mem_req_addr !== prev_addr)) stall_viol++;
            prev_stall = mem_req_valid && !mem_req_ready;
            prev_addr  = mem_req_addr;
            if (prev_stall) stall_cnt++;
            if (mem_req_valid && mem_req_ready) begin
                obs_req_addr.push_back(mem_req_addr);
                obs_req_cyc.push_back(cyc);
                p.addr = mem_req_addr;
                p.due  = cyc + mem_lat;
                pend_q.push_back(p);
                hs_tot++;
            end
            if (mdl_rsp_valid) rsp_tot++;
            if (vrf_we) begin
                r.idx  = vrf_idx;
                r.vd   = vrf_vd;
                r.data = vrf_data;
                r.done = done;
                r.cyc  = cyc;
                obs_vrf.push_back(r);
            end
        end
        @(posedge clk);
        #2;
        if (reset) begin
            pend_q.delete();
            mdl_rsp_valid = 1'b0;
        end else begin
            mem_req_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                mdl_rsp_valid = 1'b1;
                mdl_rsp_data  = mem_word(pend_q[0].addr);
                rsp_cyc_q.push_back(cyc);
                void'(pend_q.pop_front());
            end else begin
                mdl_rsp_valid = 1'b0;
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if ({cmd_ready, mem_req_valid, vrf_we, done, busy, proto_err} !== 6'b100000) begin
            n_errors++;
            $display("FAIL %s_flags: got rdy/reqv/we/done/busy/perr=%b want 100000", name,
                     {cmd_ready, mem_req_valid, vrf_we, done, busy, proto_err});
        end
        n_checks++;
        if ({mem_req_addr, vrf_idx, vrf_data, vrf_vd} !== '0) begin
            n_errors++;
            $display("FAIL %s_data: got addr=%h idx=%0d data=%h vd=%0d want all 0", name,
                     mem_req_addr, vrf_idx, vrf_data, vrf_vd);
        end
    endtask

    task automatic run_cmd(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                           input logic [VL_W-1:0] vl, input logic [REG_W-1:0] vd,
                           input int lat, input bit stall, input bit chk_timing, input string name);
        logic [ADDR_W-1:0] exp_addr[$];
        vrf_rec_t          exp_vrf[$];
        logic [ADDR_W-1:0] a;
        vrf_rec_t          e;
        vrf_rec_t          o;
        int r0, w0, p0, t_acc, budget, n;
        mem_lat  = lat;
        stall_en = stall;
        a = base;
        for (int i = 0; i < int'(vl); i++) begin
            exp_addr.push_back(a);
            e.idx  = IDX_W'(i);
            e.vd   = vd;
            e.data = mem_word(a);
            e.done = (i == int'(vl) - 1);
            e.cyc  = 0;
            exp_vrf.push_back(e);
            a = a + stride;
        end
        @(posedge clk);
        #1;
        r0 = obs_req_addr.size();
        w0 = obs_vrf.size();
        p0 = rsp_cyc_q.size();
        last_r0 = r0;
        cmd_valid  = 1'b1;
        cmd_base   = base;
        cmd_stride = stride;
        cmd_vl     = vl;
        cmd_vd     = vd;
        t_acc      = cyc;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_accept: cmd_ready=%b want 1", name, cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (done !== 1'b1 && budget < 2000);
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_done_timeout: done=%b after %0d cycles want 1", name, done, budget);
        end else begin
            n_checks++;
            if (cmd_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL %s_ready_at_done: cmd_ready=%b want 0", name, cmd_ready);
            end
            @(negedge clk);
            n_checks++;
            if ({cmd_ready, busy} !== 2'b10) begin
                n_errors++;
                $display("FAIL %s_idle_after_done: ready/busy=%b want 10", name, {cmd_ready, busy});
            end
        end
        n = obs_req_addr.size() - r0;
        n_checks++;
        if (n != int'(vl)) begin
            n_errors++;
            $display("FAIL %s_req_count: got %0d want %0d", name, n, vl);
        end
        for (int i = 0; i < n && exp_addr.size() > 0; i++) begin
            a = exp_addr.pop_front();
            n_checks++;
            if (obs_req_addr[r0+i] !== a) begin
                n_errors++;
                $display("FAIL %s_addr[%0d]: got %h want %h", name, i, obs_req_addr[r0+i], a);
            end
            if (chk_timing) begin
                n_checks++;
                if (obs_req_cyc[r0+i] != t_acc + 1 + i) begin
                    n_errors++;
                    $display("FAIL %s_req_cycle[%0d]: got %0d want %0d", name, i,
                             obs_req_cyc[r0+i] - t_acc, 1 + i);
                end
            end
        end
        n = obs_vrf.size() - w0;
        n_checks++;
        if (n != int'(vl)) begin
            n_errors++;
            $display("FAIL %s_vrf_count: got %0d want %0d", name, n, vl);
        end
        for (int i = 0; i < n && exp_vrf.size() > 0; i++) begin
            e = exp_vrf.pop_front();
            o = obs_vrf[w0+i];
            n_checks++;
            if ({o.idx, o.vd, o.data, o.done} !== {e.idx, e.vd, e.data, e.done}) begin
                n_errors++;
                $display("FAIL %s_vrf[%0d]: got idx=%0d vd=%0d data=%h done=%b want idx=%0d vd=%0d data=%h done=%b",
                         name, i, o.idx, o.vd, o.data, o.done, e.idx, e.vd, e.data, e.done);
            end
            if (p0 + i < rsp_cyc_q.size()) begin
                n_checks++;
                if (o.cyc != rsp_cyc_q[p0+i] + 1) begin
                    n_errors++;
                    $display("FAIL %s_vrf_latency[%0d]: got %0d want 1", name, i,
                             o.cyc - rsp_cyc_q[p0+i]);
                end
            end
        end
        stall_en = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_held");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_released");
    endtask

    task automatic test_basic();
        run_cmd(32'h0000_1000, 32'd8, 7'd4, 5'd3, 2, 1'b0, 1'b1, "basic");
    endtask

    task automatic test_back_to_back();
        run_cmd(32'h0000_0800, 32'd64, 7'd6, 5'd9, 1, 1'b0, 1'b1, "b2b_a");
        run_cmd(32'h0000_0900, 32'd8, 7'd2, 5'd10, 3, 1'b0, 1'b1, "b2b_b");
    endtask

    task automatic test_neg_stride();
        run_cmd(32'h0000_0010, 32'hFFFF_FFF0, 7'd3, 5'd17, 2, 1'b0, 1'b1, "neg_stride");
    endtask

    task automatic test_outstanding();
        run_cmd(32'h0001_0000, 32'd8, 7'd8, 5'd5, 10, 1'b0, 1'b0, "outstanding");
        n_checks++;
        if (max_live != MAX_OUT || full_viol != 0) begin
            n_errors++;
            $display("FAIL outstanding_limit: max=%0d viol=%0d want max=%0d viol=0",
                     max_live, full_viol, MAX_OUT);
        end
        if (obs_req_addr.size() >= last_r0 + 5) begin
            n_checks++;
            if (obs_req_cyc[last_r0+4] - obs_req_cyc[last_r0+3] <= 1) begin
                n_errors++;
                $display("FAIL outstanding_gap: req4-req3 gap=%0d want >1",
                         obs_req_cyc[last_r0+4] - obs_req_cyc[last_r0+3]);
            end
        end
    endtask

    task automatic test_stall();
        int s0;
        s0 = stall_cnt;
        run_cmd(32'h0000_2000, 32'd4, 7'd12, 5'd21, 3, 1'b1, 1'b0, "stall");
        n_checks++;
        if (stall_viol != 0 || stall_cnt == s0) begin
            n_errors++;
            $display("FAIL stall_hold: violations=%0d stalls=%0d want 0 violations and >0 stalls",
                     stall_viol, stall_cnt - s0);
        end
    endtask

    task automatic test_zero_vl();
        int r0, w0;
        @(posedge clk);
        #1;
        r0 = obs_req_addr.size();
        w0 = obs_vrf.size();
        cmd_valid  = 1'b1;
        cmd_base   = 32'h0000_3000;
        cmd_stride = 32'd8;
        cmd_vl     = '0;
        cmd_vd     = 5'd2;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, done} !== 2'b10) begin
            n_errors++;
            $display("FAIL zero_vl_T: ready/done=%b want 10", {cmd_ready, done});
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({done, mem_req_valid, cmd_ready, vrf_we} !== 4'b1010) begin
            n_errors++;
            $display("FAIL zero_vl_done: done/reqv/ready/we=%b want 1010",
                     {done, mem_req_valid, cmd_ready, vrf_we});
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || obs_req_addr.size() != r0 || obs_vrf.size() != w0) begin
            n_errors++;
            $display("FAIL zero_vl_quiet: done=%b reqs=%0d writes=%0d want 0 0 0", done,
                     obs_req_addr.size() - r0, obs_vrf.size() - w0);
        end
    endtask

    task automatic test_spurious();
        int w0;
        w0 = obs_vrf.size();
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_errors++;
            $display("FAIL spurious_pre: proto_err=%b want 0", proto_err);
        end
        @(posedge clk);
        #1;
        spur_valid = 1'b1;
        spur_data  = 64'hDEAD_BEEF_0BAD_F00D;
        @(posedge clk);
        #1;
        spur_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({vrf_we, proto_err} !== 2'b01) begin
            n_errors++;
            $display("FAIL spurious_rsp: we/proto_err=%b want 01", {vrf_we, proto_err});
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (proto_err !== 1'b1 || obs_vrf.size() != w0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL spurious_sticky: proto_err=%b writes=%0d busy=%b want 1 0 0",
                     proto_err, obs_vrf.size() - w0, busy);
        end
    endtask

    task automatic test_reset_mid_issue();
        int r0;
        mem_lat = 10;
        @(posedge clk);
        #1;
        r0 = obs_req_addr.size();
        cmd_valid  = 1'b1;
        cmd_base   = 32'h0000_4000;
        cmd_stride = 32'h20;
        cmd_vl     = 7'd5;
        cmd_vd     = 5'd7;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (obs_req_addr.size() - r0 != 2) begin
            n_errors++;
            $display("FAIL mid_reset_pre: issued=%0d want 2", obs_req_addr.size() - r0);
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset_released");
        run_cmd(32'h0000_5000, 32'd8, 7'd1, 5'd30, 2, 1'b0, 1'b1, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_neg_stride();
        test_outstanding();
        test_stall();
        test_zero_vl();
        test_spurious();
        test_reset_mid_issue();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ldp.md
# ldp

Vector load pipe: the read-side counterpart of the store pipe (`stp`). It accepts one strided vector-load command at a time and generates one memory read request per element. It collects the in-order read responses and writes each element into the vector register file, then signals completion. It sits between the vector issue stage and the memory port, alongside `stp`.

## Interface
Parameters:
- `ADDR_W`, 32, byte address width
- `DATA_W`, 64, element width
- `VLEN_MAX`, 64, maximum elements per command
- `REG_W`, 5, vector register index width
- `MAX_OUT`, 4, maximum outstanding memory reads (power of two not required, ≥1)

Ports (VL_W = $clog2(VLEN_MAX)+1, IDX_W = $clog2(VLEN_MAX), OUT_W = $clog2(MAX_OUT+1)):
- `clk` in 1, the only clock
- `reset` in 1, asynchronous, active-high
- `cmd_valid` in 1, load command present
- `cmd_ready` out 1, ldp can accept a command
- `cmd_base` in ADDR_W, byte address of element 0
- `cmd_stride` in ADDR_W, signed byte stride, two's complement
- `cmd_vl` in VL_W, element count, 0..VLEN_MAX
- `cmd_vd` in REG_W, destination vector register
- `mem_req_valid` out 1, read request present
- `mem_req_ready` in 1, memory accepts request
- `mem_req_addr` out ADDR_W, element byte address
- `mem_rsp_valid` in 1, read data returned, in request order, no backpressure
- `mem_rsp_data` in DATA_W, read data
- `vrf_we` out 1, VRF write strobe
- `vrf_vd` out REG_W, register written
- `vrf_idx` out IDX_W, element index written
- `vrf_data` out DATA_W, element data
- `done` out 1, one-cycle completion pulse
- `busy` out 1, command in progress
- `proto_err` out 1, sticky: response received with zero outstanding

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid` with `cmd_vl`=0: pulse `done` next cycle, stay IDLE.
  - On `cmd_valid` otherwise: latch vd, vl, stride; set address register = base; set issue count = 0 and response count = 0; go to ISSUE.
- ISSUE:
  - `mem_req_valid` = (outstanding < MAX_OUT).
  - On handshake: address += stride (mod 2^ADDR_W, wraps silently), issue count++, outstanding++.
  - When the handshake issues element vl-1, go to DRAIN.
- DRAIN: no requests. When response count reaches vl, go to IDLE.
- Responses are accepted in any state:
  - Each response is element number = response count.
  - Registered to the VRF port: `vrf_we`, `vrf_idx`, `vrf_data` and `vrf_vd` are valid in the cycle after `mem_rsp_valid`.
  - Response count++ and outstanding-- on each response.
- Simultaneous request handshake and response: outstanding unchanged.
- Response while outstanding = 0:
  - Set `proto_err` (cleared only by reset).
  - No VRF write, no counter change.
- `done` pulses in the same cycle as the VRF write of element vl-1.
- `busy` = state ≠ IDLE, or a VRF write is pending.
- Reset, any cycle:
  - State returns to IDLE; all counters are zeroed.
  - Outputs after reset: `cmd_ready`=1. `mem_req_valid`, `vrf_we`, `done`, `busy` and `proto_err` are 0. All data, address and index outputs are 0.
  - Memory in-flight state is cleared by the same reset.

## Timing
- Command accepted at cycle T → first `mem_req_valid` at T+1.
- With `mem_req_ready` held high: one request per cycle, T+1..T+vl.
- Response at cycle R → VRF write at R+1.
- Last response at R_last → `done` and final write at R_last+1, IDLE (`cmd_ready`=1) at R_last+2.
- `mem_req_addr` is held stable while `mem_req_valid`=1 and `mem_req_ready`=0.
- Minimum command-to-command spacing: vl + memory latency + 2 cycles.

## Structure
- Shared `vector_pkg`: `ldp_state_t` enum (IDLE/ISSUE/DRAIN), and `VLEN_MAX`, `REG_W` defaults shared with `stp`.
- One natural sub-module, `ldp_addr_gen`: base/stride accumulator with issue counter and a last-element flag.
- Outstanding counter and VRF write register stay in `ldp`.

## Test plan
- base=0x1000, stride=8, vl=4, memory latency 2, ready=1 → addresses 0x1000, 0x1008, 0x1010, 0x1018 on consecutive cycles; VRF writes at idx 0..3 in order; one `done`.
- stride=-16 (0xFFFFFFF0), base=0x10, vl=3 → addresses 0x10, 0x0, 0xFFFFFFF0 (wrap).
- Memory latency 10, MAX_OUT=4, vl=8 → `mem_req_valid` deasserts after 4 requests; outstanding never exceeds 4; all 8 elements are written.
- Random `mem_req_ready` stalls → address stable during stall; no request is lost or duplicated.
- vl=0 → no memory request, no VRF write, `done` at T+1. A spurious response in IDLE → `proto_err`=1 with no write.
- Reset asserted mid-ISSUE after 2 of 5 requests → all outputs at reset values; a new command with vl=1 then completes normally.
